// File: rtl/datapath_param_if.sv
// Decoder <-> datapath bundle: register fields, immediate, control strobes,
// and the returned pc/flags/port/stall signals.
interface datapath_param_if #(
  parameter int unsigned DW    = 4,
  parameter int unsigned PW    = 4,
  parameter int unsigned RAW   = 3,
  parameter int unsigned NPORT = 2
);
  logic [RAW-1:0]        ra1;
  logic [RAW-1:0]        ra2;
  logic [RAW-1:0]        wa;
  logic [DW-1:0]         imm;
  logic                  reg_write;
  logic                  mem_write;
  logic                  mem_read;
  logic                  alu_src;
  logic                  pc_src;
  logic                  port_write;
  logic                  flag_we;
  logic [3:0]            alu_op;
  logic [1:0]            wb_sel;
  logic [NPORT*DW-1:0]   port_in;
  logic [PW-1:0]         pc;
  logic [3:0]            alu_flags;
  logic [NPORT*DW-1:0]   port_data;
  logic                  stall;

  modport master (
    output ra1, ra2, wa, imm, reg_write, mem_write, mem_read, alu_src,
           pc_src, port_write, flag_we, alu_op, wb_sel, port_in,
    input  pc, alu_flags, port_data, stall
  );

  modport slave (
    input  ra1, ra2, wa, imm, reg_write, mem_write, mem_read, alu_src,
           pc_src, port_write, flag_we, alu_op, wb_sel, port_in,
    output pc, alu_flags, port_data, stall
  );
endinterface

// File: rtl/datapath_param.sv
// Parametrised datapath: register file, ALU, flags, data RAM, output ports, load-stall FSM.
// Optional DP_ZERO_REG_EN: R0 reads as zero and ignores writes.
module datapath_param #(
  parameter int unsigned DW     = 4,
  parameter int unsigned PW     = 4,
  parameter int unsigned RAW    = 3,
  parameter int unsigned NPORT  = 2,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  datapath_param_if.slave  dp
);
  localparam int unsigned NREG  = 2**RAW;
  localparam int unsigned DEPTH = 2**DW;
  localparam int unsigned CW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
`ifdef DP_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {EXEC, LOAD_WAIT} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic                stall;
  logic                upd;

  logic [DW-1:0]       regs    [NREG];
  logic [DW-1:0]       ram     [DEPTH];
  logic [DW-1:0]       rd_pipe [RD_LAT];
  logic [DW-1:0]       src1, rd2, src2;
  logic [DW-1:0]       alu_res, wb_data, port_sel;
  logic [DW:0]         sum;
  logic                alu_c, alu_v;
  logic [3:0]          flags_nx;
  logic [PW-1:0]       pc_q, pc_inc;
  logic [3:0]          flags_q;
  logic [NPORT*DW-1:0] port_q;
  logic                wr_ok;

  // Operand fetch; reads see the pre-edge register contents
  always_comb begin
    src1 = regs[dp.ra1];
    rd2  = regs[dp.ra2];
    if (ZERO_REG && dp.ra1 == '0) src1 = '0;
    if (ZERO_REG && dp.ra2 == '0) rd2  = '0;
    src2 = dp.alu_src ? dp.imm : rd2;
  end

  always_comb begin
    alu_res = '0;
    sum     = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (dp.alu_op)
      4'd0: begin
        sum     = {1'b0, src1} + {1'b0, src2};
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = (src1[DW-1] == src2[DW-1]) && (alu_res[DW-1] != src1[DW-1]);
      end
      4'd1: begin
        sum     = {1'b0, src1} + {1'b0, ~src2} + {{DW{1'b0}}, 1'b1};
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = (src1[DW-1] != src2[DW-1]) && (alu_res[DW-1] != src1[DW-1]);
      end
      4'd2: alu_res = src1 & src2;
      4'd3: alu_res = src1 | src2;
      4'd4: alu_res = src1 ^ src2;
      4'd5: alu_res = ~src1;
      4'd6: begin
        alu_res = src1 << 1;
        alu_c   = src1[DW-1];
      end
      4'd7: begin
        alu_res = src1 >> 1;
        alu_c   = src1[0];
      end
      4'd8: alu_res = src2;
      default: alu_res = '0;
    endcase
    flags_nx = {alu_res[DW-1], (alu_res == '0), alu_c, alu_v};
  end

  // Input port select for write-back; out-of-range index yields zero
  always_comb begin
    port_sel = '0;
    for (int unsigned k = 0; k < NPORT; k++)
      if (32'(src2) == k) port_sel = dp.port_in[k*DW +: DW];
  end

  always_comb begin
    pc_inc = pc_q + PW'(1);
    case (dp.wb_sel)
      2'd0:    wb_data = alu_res;
      2'd1:    wb_data = DW'(pc_inc);
      2'd2:    wb_data = rd_pipe[RD_LAT-1];
      default: wb_data = port_sel;
    endcase
    wr_ok = dp.reg_write && !(ZERO_REG && dp.wa == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EXEC;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Load FSM: the issuing cycle and all but the last wait cycle stall
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    case (state)
      EXEC: begin
        if (dp.mem_read) begin
          stall    = 1'b1;
          cnt_nx   = CW'(RD_LAT - 1);
          state_nx = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        if (cnt != '0) begin
          stall  = 1'b1;
          cnt_nx = cnt - CW'(1);
        end else begin
          state_nx = EXEC;
        end
      end
      default: state_nx = EXEC;
    endcase
    upd = !stall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      flags_q <= '0;
      port_q  <= '0;
      for (int unsigned r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (upd) begin
      pc_q <= dp.pc_src ? PW'(src2) : pc_inc;
      if (state == EXEC && dp.flag_we) flags_q <= flags_nx;
      if (wr_ok) regs[dp.wa] <= wb_data;
      if (dp.port_write)
        for (int unsigned k = 0; k < NPORT; k++)
          if (32'(src2) == k) port_q[k*DW +: DW] <= src1;
    end
  end

  // RAM is not reset; read data enters a RD_LAT-deep pipe at load issue
  always_ff @(posedge clk) begin
    if (upd && dp.mem_write && !dp.mem_read) ram[src2] <= rd2;
    if (state == EXEC && dp.mem_read) rd_pipe[0] <= ram[src1];
    for (int unsigned i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign dp.pc        = pc_q;
  assign dp.alu_flags = flags_q;
  assign dp.port_data = port_q;
  assign dp.stall     = stall;
endmodule

// File: tb/tb_datapath_param.sv
// Scoreboard bench for datapath_param: directed and random instructions against an
// arithmetic reference model; a monitor checks stall, pc, flags and ports every cycle.
module tb_datapath_param;
  localparam int unsigned DW     = 4;
  localparam int unsigned PW     = 4;
  localparam int unsigned RAW    = 3;
  localparam int unsigned NPORT  = 2;
  localparam int unsigned RD_LAT = 3;
  localparam int unsigned NREG   = 2**RAW;
  localparam int M   = 2**DW;
  localparam int PCM = 2**PW;
`ifdef DP_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  typedef struct packed {
    logic [RAW-1:0] ra1, ra2, wa;
    logic [DW-1:0]  imm;
    logic rw, mw, mr, as, ps, pw, fw;
    logic [3:0] op;
    logic [1:0] wb;
    logic [NPORT*DW-1:0] pin;
  } instr_t;

  typedef struct packed {
    logic                stall;
    logic [PW-1:0]       pc;
    logic [3:0]          flags;
    logic [NPORT*DW-1:0] ports;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   nchecks = 0;
  int   nerrors = 0;
  exp_t exp_q[$];

  int         m_regs[NREG];
  int         m_ram[M];
  int         m_ports[NPORT];
  int         m_pc;
  logic [3:0] m_flags;

  datapath_param_if #(.DW(DW), .PW(PW), .RAW(RAW), .NPORT(NPORT)) dp ();
  datapath_param #(.DW(DW), .PW(PW), .RAW(RAW), .NPORT(NPORT), .RD_LAT(RD_LAT))
    dut (.clk(clk), .reset(reset), .dp(dp));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rdreg(input int r);
    return (ZR && r == 0) ? 0 : m_regs[r];
  endfunction

  function automatic int sgn(input int x);
    return (x >= M/2) ? x - M : x;
  endfunction

  task automatic alu_model(input int a, input int b, input int op,
                           output int res, output logic [3:0] fl);
    int s;
    logic c, v;
    c = 1'b0; v = 1'b0;
    case (op)
      0: begin s = a + b; res = s % M; c = (s >= M);
               s = sgn(a) + sgn(b); v = (s > M/2 - 1) || (s < -M/2); end
      1: begin res = (a - b + M) % M; c = (a >= b);
               s = sgn(a) - sgn(b); v = (s > M/2 - 1) || (s < -M/2); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = M - 1 - a;
      6: begin res = (a * 2) % M; c = (a >= M/2); end
      7: begin res = a / 2; c = (a % 2) == 1; end
      8: res = b;
      default: res = 0;
    endcase
    fl = {res >= M/2, res == 0, c, v};
  endtask

  task automatic exec_model(input instr_t i);
    int a, r2, b, res, wbv, pin;
    logic [3:0] fl;
    a  = rdreg(int'(i.ra1));
    r2 = rdreg(int'(i.ra2));
    b  = i.as ? int'(i.imm) : r2;
    alu_model(a, b, int'(i.op), res, fl);
    pin = int'(i.pin);
    case (i.wb)
      2'd0:    wbv = res;
      2'd1:    wbv = ((m_pc + 1) % PCM) % M;
      2'd2:    wbv = m_ram[a];
      default: wbv = (b < int'(NPORT)) ? (pin >> (b * DW)) % M : 0;
    endcase
    if (i.rw && !(ZR && i.wa == 0)) m_regs[i.wa] = wbv;
    if (!i.mr && i.fw) m_flags = fl;
    if (!i.mr && i.mw) m_ram[b] = r2;
    if (i.pw && b < int'(NPORT)) m_ports[b] = a;
    m_pc = i.ps ? b % PCM : (m_pc + 1) % PCM;
  endtask

  task automatic model_reset();
    for (int r = 0; r < int'(NREG); r++) m_regs[r] = 0;
    for (int k = 0; k < int'(NPORT); k++) m_ports[k] = 0;
    m_pc = 0;
    m_flags = 4'h0;
  endtask

  function automatic exp_t snap(input bit st);
    exp_t e;
    e.stall = st;
    e.pc    = PW'(m_pc);
    e.flags = m_flags;
    e.ports = '0;
    for (int k = 0; k < int'(NPORT); k++) e.ports[k*DW +: DW] = DW'(m_ports[k]);
    return e;
  endfunction

  // ---------------- stimulus ----------------
  function automatic instr_t nop();
    instr_t i;
    i = '0;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    dp.ra1 = i.ra1; dp.ra2 = i.ra2; dp.wa = i.wa; dp.imm = i.imm;
    dp.reg_write = i.rw; dp.mem_write = i.mw; dp.mem_read = i.mr;
    dp.alu_src = i.as; dp.pc_src = i.ps; dp.port_write = i.pw;
    dp.flag_we = i.fw; dp.alu_op = i.op; dp.wb_sel = i.wb; dp.port_in = i.pin;
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction retires
  task automatic send(input instr_t i);
    drive(i);
    if (i.mr)
      for (int c = 0; c < int'(RD_LAT); c++) exp_q.push_back(snap(1'b1));
    exec_model(i);
    exp_q.push_back(snap(1'b0));
    repeat (i.mr ? RD_LAT + 1 : 1) @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input int r, input int v);
    instr_t i;
    i = nop(); i.wa = RAW'(r); i.imm = DW'(v); i.as = 1'b1; i.op = 4'd8; i.rw = 1'b1;
    send(i);
  endtask

  task automatic show(input int r, input int port);
    instr_t i;
    i = nop(); i.ra1 = RAW'(r); i.as = 1'b1; i.imm = DW'(port); i.pw = 1'b1;
    send(i);
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    int w;
    i.ra1 = RAW'($urandom_range(0, NREG-1));
    i.ra2 = RAW'($urandom_range(0, NREG-1));
    i.wa  = RAW'($urandom_range(0, NREG-1));
    i.imm = DW'($urandom_range(0, M-1));
    i.rw = 1'($urandom); i.mw = 1'($urandom); i.as = 1'($urandom);
    i.pw = 1'($urandom); i.fw = 1'($urandom);
    i.mr = ($urandom_range(0, 4) == 0);
    i.ps = ($urandom_range(0, 7) == 0);
    i.op = 4'($urandom_range(0, 10));
    w = int'($urandom_range(0, 2));
    i.wb = i.mr ? 2'd2 : ((w == 2) ? 2'd3 : 2'(w));
    i.pin = (NPORT*DW)'($urandom);
    return i;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stall", 32'(dp.stall), 32'(e.stall));
        @(posedge clk);
        #2;
        chk("pc", 32'(dp.pc), 32'(e.pc));
        chk("alu_flags", 32'(dp.alu_flags), 32'(e.flags));
        chk("port_data", 32'(dp.port_data), 32'(e.ports));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    instr_t i;
    reset = 1'b1;
    drive(nop());
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", 32'(dp.pc), 32'h0);
    chk("reset_flags", 32'(dp.alu_flags), 32'h0);
    chk("reset_ports", 32'(dp.port_data), 32'h0);
    chk("reset_stall", 32'(dp.stall), 32'h0);
    reset = 1'b0;

    // give every RAM word a known value
    for (int a = 0; a < M; a++) begin
      set_reg(1, (a ^ 5) % M);
      i = nop(); i.ra2 = 3'd1; i.as = 1'b1; i.imm = DW'(a); i.mw = 1'b1;
      send(i);
    end

    // ADD 9+7 -> 0, flags N=0 Z=1 C=1 V=0
    set_reg(1, 9);
    i = nop(); i.ra1 = 3'd1; i.as = 1'b1; i.imm = 4'd7; i.op = 4'd0; i.fw = 1'b1;
    i.rw = 1'b1; i.wa = 3'd2;
    send(i);
    chk("add_flags", 32'(dp.alu_flags), 32'b0110);

    // SUB 3-5 -> 0xE, flags N=1 Z=0 C=0 V=0
    set_reg(1, 3);
    i = nop(); i.ra1 = 3'd1; i.as = 1'b1; i.imm = 4'd5; i.op = 4'd1; i.fw = 1'b1;
    i.rw = 1'b1; i.wa = 3'd6;
    send(i);
    chk("sub_flags", 32'(dp.alu_flags), 32'b1000);
    show(6, 0);
    chk("sub_result", 32'(dp.port_data[3:0]), 32'hE);

    // store R2=0xA at 3, load address 3 into R4
    set_reg(2, 4'hA);
    i = nop(); i.ra2 = 3'd2; i.as = 1'b1; i.imm = 4'd3; i.mw = 1'b1;
    send(i);
    set_reg(7, 3);
    i = nop(); i.ra1 = 3'd7; i.mr = 1'b1; i.rw = 1'b1; i.wb = 2'd2; i.wa = 3'd4;
    send(i);
    show(4, 1);
    chk("load_result", 32'(dp.port_data[7:4]), 32'hA);

    // jump to 0xF then wrap
    i = nop(); i.ps = 1'b1; i.as = 1'b1; i.imm = 4'hF;
    send(i);
    chk("jump_pc", 32'(dp.pc), 32'hF);
    send(nop());
    chk("wrap_pc", 32'(dp.pc), 32'h0);

    // link value at pc=4
    i = nop(); i.ps = 1'b1; i.as = 1'b1; i.imm = 4'd4;
    send(i);
    i = nop(); i.wb = 2'd1; i.rw = 1'b1; i.wa = 3'd5;
    send(i);
    show(5, 0);
    chk("link_value", 32'(dp.port_data[3:0]), 32'h5);

    show(6, 2);   // out-of-range port, no change
    chk("port_oob", 32'(dp.port_data), 32'hA5);

    // input port 0 = 0xC from port_in 0x3C
    i = nop(); i.as = 1'b1; i.imm = 4'd0; i.wb = 2'd3; i.rw = 1'b1; i.wa = 3'd3;
    i.pin = 8'h3C;
    send(i);
    show(3, 0);
    chk("port_in_wb", 32'(dp.port_data[3:0]), 32'hC);

    set_reg(0, 7);
    show(0, 0);
    chk("r0_read", 32'(dp.port_data[3:0]), ZR ? 32'h0 : 32'h7);

    // simultaneous load and store: store must be dropped
    set_reg(2, 9);
    i = nop(); i.ra1 = 3'd7; i.ra2 = 3'd2; i.as = 1'b1; i.imm = 4'd3;
    i.mr = 1'b1; i.mw = 1'b1; i.rw = 1'b1; i.wb = 2'd2; i.wa = 3'd5;
    send(i);
    i = nop(); i.ra1 = 3'd7; i.mr = 1'b1; i.rw = 1'b1; i.wb = 2'd2; i.wa = 3'd5;
    send(i);
    show(5, 0);
    chk("ram_conflict", 32'(dp.port_data[3:0]), 32'hA);

    for (int n = 0; n < 300; n++) send(rand_instr());

    // async reset mid-cycle
    set_reg(1, 5);
    show(1, 0);
    drive(nop());
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_pc", 32'(dp.pc), 32'h0);
    chk("async_rst_flags", 32'(dp.alu_flags), 32'h0);
    chk("async_rst_ports", 32'(dp.port_data), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    show(1, 0);
    chk("r1_after_reset", 32'(dp.port_data[3:0]), 32'h0);

    // reset during LOAD_WAIT aborts the load
    set_reg(7, 3);
    i = nop(); i.ra1 = 3'd7; i.mr = 1'b1; i.rw = 1'b1; i.wb = 2'd2; i.wa = 3'd1;
    drive(i);
    @(posedge clk);
    #1;
    chk("load_wait_stall", 32'(dp.stall), 32'h1);
    #2;
    drive(nop());
    reset = 1'b1;
    #1;
    chk("abort_pc", 32'(dp.pc), 32'h0);
    chk("abort_stall", 32'(dp.stall), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    show(1, 0);
    send(nop());

    while (exp_q.size() != 0) @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
